// File: rtl/rvm_shift_issue_if.sv
// Core-side request/response handshake plus the issue port to the external shift unit.
// master = core + shift unit side, slave = the issue block.
interface rvm_shift_issue_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_instr;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_illegal;
   logic        rsp_error;
   logic [31:0] shf_lhs;
   logic [4:0]  shf_rhs;
   logic [1:0]  shf_op;
   logic        shf_valid;
   logic [32:0] shf_result;

   modport master (
      output req_valid, req_instr, req_rs1, req_rs2, rsp_ready, shf_valid, shf_result,
      input  req_ready, rsp_valid, rsp_result, rsp_illegal, rsp_error,
             shf_lhs, shf_rhs, shf_op
   );

   modport slave (
      input  req_valid, req_instr, req_rs1, req_rs2, rsp_ready, shf_valid, shf_result,
      output req_ready, rsp_valid, rsp_result, rsp_illegal, rsp_error,
             shf_lhs, shf_rhs, shf_op
   );
endinterface

// File: rtl/rvm_shift_issue.sv
// Decodes RV32I shift instructions, issues them to an external shift unit and
// returns the result (or illegal / timeout status) through a held response.
module rvm_shift_issue #(
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input logic              g_clk,
   input logic              g_resetn,
   rvm_shift_issue_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [3:0] CNT_LAST   = 4'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;

   logic [1:0]  op_q;
   logic [31:0] lhs_q;
   logic [4:0]  amt_q;
   logic [3:0]  cnt_q;
   logic [31:0] result_q;
   logic        illegal_q;
   logic        error_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_op;
   logic        is_imm;
   logic [1:0]  dec_op;
   logic [4:0]  dec_amt;
   logic        dec_legal;
   logic        accept;
   logic        in_issue;
   logic        in_resp;
   logic        timeout_hit;
   logic        unused_bits;

   // ---------------------------------------------------------------- decode
   assign opcode = bus.req_instr[6:0];
   assign funct3 = bus.req_instr[14:12];
   assign funct7 = bus.req_instr[31:25];
   assign is_op  = (opcode == OPC_OP);
   assign is_imm = (opcode == OPC_OP_IMM);

   always_comb begin
      dec_op = OP_NOP;
      if (is_op || is_imm) begin
         if (funct3 == 3'b001 && funct7 == F7_ZERO)
            dec_op = OP_SLL;
         else if (funct3 == 3'b101 && funct7 == F7_ZERO)
            dec_op = OP_SRL;
         else if (funct3 == 3'b101 && funct7 == F7_ALT)
            dec_op = OP_SRA;
      end
   end

   // NOP never comes out of a legal decode, so it doubles as the illegal flag.
   assign dec_legal = (dec_op != OP_NOP);
   assign dec_amt   = is_op ? bus.req_rs2[4:0] : bus.req_instr[24:20];

   assign unused_bits = ^{bus.shf_result[32], bus.req_instr[19:15], bus.req_instr[11:7],
                          bus.req_rs2[31:5]};

   // ---------------------------------------------------------------- control
   assign in_issue = (state == ISSUE);
   assign in_resp  = (state == RESP);
   assign accept   = bus.req_valid && (state == IDLE);

   // A result arriving on the last allowed cycle wins over the timeout.
   assign timeout_hit = !bus.shf_valid && (cnt_q == CNT_LAST);

   always_ff @(posedge g_clk) begin
      if (!g_resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = dec_legal ? ISSUE : RESP;
         end
         ISSUE: begin
            if (bus.shf_valid || timeout_hit)
               state_nxt = RESP;
         end
         RESP: begin
            if (bus.rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         op_q      <= OP_NOP;
         lhs_q     <= '0;
         amt_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q      <= dec_op;
                  lhs_q     <= bus.req_rs1;
                  amt_q     <= dec_amt;
                  cnt_q     <= '0;
                  result_q  <= '0;
                  illegal_q <= !dec_legal;
                  error_q   <= 1'b0;
               end
            end
            ISSUE: begin
               if (bus.shf_valid) begin
                  result_q <= bus.shf_result[31:0];
               end else begin
                  cnt_q <= cnt_q + 4'd1;
                  if (timeout_hit) begin
                     result_q <= '0;
                     error_q  <= 1'b1;
                  end
               end
            end
            RESP: begin
               // Response fields are frozen here until consumed, then cleared.
               if (bus.rsp_ready) begin
                  result_q  <= '0;
                  illegal_q <= 1'b0;
                  error_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.req_ready   = (state == IDLE);
   assign bus.rsp_valid   = in_resp;
   assign bus.rsp_result  = result_q;
   assign bus.rsp_illegal = in_resp && illegal_q;
   assign bus.rsp_error   = in_resp && error_q;

   // Operand isolation: the unit sees zeros whenever nothing is being issued.
   assign bus.shf_op  = in_issue ? op_q  : OP_NOP;
   assign bus.shf_lhs = in_issue ? lhs_q : '0;
   assign bus.shf_rhs = in_issue ? amt_q : '0;

endmodule

// File: tb/tb_rvm_shift_issue.sv
// Bench for rvm_shift_issue: behavioural shift unit with programmable delay,
// spec-level reference decode, directed and randomized scenarios.
module tb_rvm_shift_issue;

   localparam int T = 8;

   logic g_clk;
   logic g_resetn;
   int   tests;
   int   fails;
   int   unit_delay;
   int   wait_cnt;
   logic [31:0] unit_res;

   rvm_shift_issue_if bus ();

   rvm_shift_issue #(.TIMEOUT_CYCLES(T)) dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .bus      (bus)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // Shift unit model: responds unit_delay cycles after an op first appears.
   always @(posedge g_clk) begin
      if (bus.shf_op == 2'b00)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
   end

   always_comb begin
      unit_res = 32'h0;
      case (bus.shf_op)
         2'b01: unit_res = bus.shf_lhs << bus.shf_rhs;
         2'b10: unit_res = bus.shf_lhs >> bus.shf_rhs;
         2'b11: unit_res = 32'($signed(bus.shf_lhs) >>> bus.shf_rhs);
         default: unit_res = 32'h0;
      endcase
   end

   assign bus.shf_valid  = (bus.shf_op != 2'b00) && (wait_cnt >= unit_delay);
   assign bus.shf_result = {1'b1, unit_res};

   // Reference: RV32I shift semantics straight from the instruction encoding.
   function automatic void ref_decode(input logic [31:0] instr, input logic [31:0] rs1,
                                      input logic [31:0] rs2, output bit legal,
                                      output logic [1:0] op, output logic [4:0] amt,
                                      output logic [31:0] res);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [31:0] fill;
      opc = instr[6:0];
      f3  = instr[14:12];
      f7  = instr[31:25];
      amt = (opc == 7'h33) ? rs2[4:0] : instr[24:20];
      op = 2'b00;
      if (opc == 7'h33 || opc == 7'h13) begin
         if (f3 == 3'd1 && f7 == 7'h00) op = 2'b01;
         if (f3 == 3'd5 && f7 == 7'h00) op = 2'b10;
         if (f3 == 3'd5 && f7 == 7'h20) op = 2'b11;
      end
      legal = (op != 2'b00);
      fill  = rs1[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0;
      case (op)
         2'b01:   res = rs1 * (32'd1 << amt);
         2'b10:   res = rs1 >> amt;
         2'b11:   res = (rs1 >> amt) | fill;
         default: res = 32'h0;
      endcase
   endfunction

   task automatic drive_idle();
      bus.req_valid = 1'b0;
      bus.req_instr = 32'h0;
      bus.req_rs1   = 32'h0;
      bus.req_rs2   = 32'h0;
      bus.rsp_ready = 1'b0;
   endtask

   // One full transaction: accept, operand check, latency, held response, handoff.
   task automatic run_txn(input string name, input logic [31:0] instr, input logic [31:0] rs1,
                          input logic [31:0] rs2, input int delay, input int lag);
      bit          legal;
      bit          exp_err;
      logic [1:0]  op;
      logic [4:0]  amt;
      logic [31:0] res;
      logic [31:0] exp_res;
      int          exp_lat;
      int          c;
      ref_decode(instr, rs1, rs2, legal, op, amt, res);
      exp_err    = legal && (delay >= T);
      exp_lat    = !legal ? 1 : (exp_err ? T + 1 : delay + 2);
      exp_res    = (legal && !exp_err) ? res : 32'h0;
      unit_delay = delay;

      c = 0;
      while (!bus.req_ready && c < 50) begin
         @(negedge g_clk);
         c++;
      end
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s ready_wait: req_ready=%b after %0d cycles, want 1", name, bus.req_ready, c);
      end

      bus.req_valid = 1'b1;
      bus.req_instr = instr;
      bus.req_rs1   = rs1;
      bus.req_rs2   = rs2;
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      bus.req_instr = $urandom;
      bus.req_rs1   = $urandom;
      bus.req_rs2   = $urandom;
      c = 1;

      tests++;
      if (legal) begin
         if ({bus.shf_op, bus.shf_lhs, bus.shf_rhs} !== {op, rs1, amt}) begin
            fails++;
            $display("FAIL %s issue_ops: op=%b lhs=%h rhs=%0d want op=%b lhs=%h rhs=%0d",
                     name, bus.shf_op, bus.shf_lhs, bus.shf_rhs, op, rs1, amt);
         end
      end else if ({bus.shf_op, bus.shf_lhs, bus.shf_rhs} !== 39'h0) begin
         fails++;
         $display("FAIL %s illegal_isolation: op=%b lhs=%h rhs=%0d want all 0",
                  name, bus.shf_op, bus.shf_lhs, bus.shf_rhs);
      end

      while (!bus.rsp_valid && c < 40) begin
         @(negedge g_clk);
         c++;
      end
      tests++;
      if (c !== exp_lat) begin
         fails++;
         $display("FAIL %s latency: got %0d cycles want %0d", name, c, exp_lat);
      end

      for (int k = 0; k <= lag; k++) begin
         tests++;
         if ({bus.rsp_valid, bus.rsp_result, bus.rsp_illegal, bus.rsp_error, bus.req_ready,
              bus.shf_op} !== {1'b1, exp_res, !legal, exp_err, 1'b0, 2'b00}) begin
            fails++;
            $display("FAIL %s resp[%0d]: v=%b res=%h ill=%b err=%b rdy=%b op=%b want v=1 res=%h ill=%b err=%b rdy=0 op=00",
                     name, k, bus.rsp_valid, bus.rsp_result, bus.rsp_illegal, bus.rsp_error,
                     bus.req_ready, bus.shf_op, exp_res, !legal, exp_err);
         end
         if (k < lag) @(negedge g_clk);
      end

      bus.rsp_ready = 1'b1;
      @(negedge g_clk);
      bus.rsp_ready = 1'b0;
      tests++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_illegal, bus.rsp_error} !== 4'b0100) begin
         fails++;
         $display("FAIL %s handoff: rsp_valid=%b req_ready=%b ill=%b err=%b want 0 1 0 0",
                  name, bus.rsp_valid, bus.req_ready, bus.rsp_illegal, bus.rsp_error);
      end
   endtask

   task automatic test_reset();
      drive_idle();
      unit_delay = 0;
      g_resetn   = 1'b0;
      repeat (3) @(negedge g_clk);
      g_resetn = 1'b1;
      tests++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_illegal, bus.rsp_error} !== 4'b1000) begin
         fails++;
         $display("FAIL reset_flags: rdy=%b v=%b ill=%b err=%b want 1 0 0 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_illegal, bus.rsp_error);
      end
      tests++;
      if ({bus.rsp_result, bus.shf_op, bus.shf_lhs, bus.shf_rhs} !== 71'h0) begin
         fails++;
         $display("FAIL reset_data: res=%h op=%b lhs=%h rhs=%0d want all 0",
                  bus.rsp_result, bus.shf_op, bus.shf_lhs, bus.shf_rhs);
      end
   endtask

   task automatic test_directed();
      run_txn("sll_max", 32'h0000_1033, 32'h0000_0001, 32'h0000_003F, 0, 0);
      run_txn("srai_4", 32'h4041_5093, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_txn("illegal_f7", 32'h0200_1033, 32'h1234_5678, 32'h0000_0003, 0, 0);
      run_txn("srl_hold", 32'h0000_5033, 32'hF000_000F, 32'h0000_0004, 0, 3);
      run_txn("slli_delay", 32'h0070_9013, 32'h0000_00FF, 32'h0, 3, 1);
      run_txn("bad_opcode", 32'h0000_1013 ^ 32'h0000_0040, 32'h1, 32'h1, 0, 0);
   endtask

   task automatic test_timeout();
      run_txn("timeout", 32'h0000_5033, 32'hDEAD_BEEF, 32'h2, 100, 2);
      run_txn("last_cycle_valid", 32'h4000_5033, 32'h8000_0001, 32'h1, T - 1, 0);
      run_txn("after_timeout", 32'h0000_1033, 32'h3, 32'h2, 0, 0);
   endtask

   task automatic test_reset_mid();
      int c;
      // Reset while waiting on the unit: the request vanishes without a response.
      unit_delay    = 100;
      bus.req_valid = 1'b1;
      bus.req_instr = 32'h0000_1033;
      bus.req_rs1   = 32'h5;
      bus.req_rs2   = 32'h1;
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge g_clk);
      g_resetn = 1'b0;
      @(negedge g_clk);
      g_resetn = 1'b1;
      tests++;
      if ({bus.req_ready, bus.rsp_valid, bus.shf_op} !== 4'b1000) begin
         fails++;
         $display("FAIL reset_issue: rdy=%b v=%b op=%b want 1 0 00", bus.req_ready, bus.rsp_valid, bus.shf_op);
      end
      repeat (3) @(negedge g_clk);
      tests++;
      if (bus.rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_issue_drop: rsp_valid=%b want 0", bus.rsp_valid);
      end

      // Reset while a response is held.
      unit_delay    = 0;
      bus.req_valid = 1'b1;
      bus.req_instr = 32'h0000_5033;
      bus.req_rs1   = 32'hFFFF_0000;
      bus.req_rs2   = 32'h8;
      @(negedge g_clk);
      bus.req_valid = 1'b0;
      c = 1;
      while (!bus.rsp_valid && c < 20) begin
         @(negedge g_clk);
         c++;
      end
      tests++;
      if (bus.rsp_result !== 32'h00FF_FF00) begin
         fails++;
         $display("FAIL reset_resp_pre: res=%h want 00ffff00", bus.rsp_result);
      end
      g_resetn = 1'b0;
      @(negedge g_clk);
      g_resetn = 1'b1;
      tests++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_result} !== {2'b01, 32'h0}) begin
         fails++;
         $display("FAIL reset_resp: v=%b rdy=%b res=%h want 0 1 0", bus.rsp_valid, bus.req_ready, bus.rsp_result);
      end
      run_txn("sll_after_reset", 32'h0000_1033, 32'h0000_0003, 32'h0000_0004, 0, 0);
   endtask

   task automatic spacing_run(input string name, input logic [31:0] instr, input int want);
      int last;
      last          = -1;
      unit_delay    = 0;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_instr = instr;
      bus.req_rs1   = $urandom;
      bus.req_rs2   = $urandom;
      for (int cyc = 0; cyc < 13; cyc++) begin
         if (bus.req_ready) begin
            if (last >= 0) begin
               tests++;
               if (cyc - last !== want) begin
                  fails++;
                  $display("FAIL %s spacing: got %0d cycles want %0d", name, cyc - last, want);
               end
            end
            last = cyc;
         end
         @(negedge g_clk);
      end
      bus.req_valid = 1'b0;
      repeat (4) @(negedge g_clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      spacing_run("b2b_legal", 32'h0000_1033, 3);
      spacing_run("b2b_illegal", 32'h0000_2033, 2);
   endtask

   task automatic test_random();
      logic [31:0] instr;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int          r;
      for (int i = 0; i < 40; i++) begin
         instr = $urandom;
         r = $urandom_range(3, 0);
         opc = (r < 2) ? 7'h33 : (r == 2) ? 7'h13 : instr[6:0];
         r = $urandom_range(3, 0);
         f3 = (r == 0) ? 3'd1 : (r < 3) ? 3'd5 : instr[14:12];
         r = $urandom_range(3, 0);
         f7 = (r == 1) ? 7'h20 : (r == 2) ? instr[31:25] : 7'h00;
         instr = {f7, instr[24:15], f3, instr[11:7], opc};
         run_txn("random", instr, $urandom, $urandom, $urandom_range(9, 0), $urandom_range(3, 0));
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
